// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter and its load-result buffer.
package wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // One buffered load result: destination register and data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result buffer for the writeback arbiter: circular FIFO with
// WAW kill (matching entries have rd cleared) and next-state per-entry
// rd/valid outputs so the owner can register an exact busy mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                                  Clk,
  input  logic                                  Reset,
  input  logic                                  enq,
  input  wb_entry_t                             enq_entry,
  input  logic                                  deq,
  input  logic                                  kill_en,
  input  logic [REG_ADDR_W-1:0]                 kill_rd,
  output logic                                  ready,
  output logic                                  head_vld,
  output wb_entry_t                             head,
  output logic [FIFO_DEPTH-1:0]                 nxt_vld,
  output logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] nxt_rd
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t       mem   [FIFO_DEPTH];
  wb_entry_t       mem_n [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, rd_ptr_n;
  logic [PW-1:0]   wr_ptr, wr_ptr_n;
  logic [CW-1:0]   count, count_n;
  logic            rst_q;
  logic            do_enq;
  logic            do_deq;
  logic [PW-1:0]   ofs;

  // Ready comes from registers only; rst_q holds it low after a reset edge.
  assign ready    = !rst_q && (count < CW'(FIFO_DEPTH));
  assign head_vld = (count != '0);
  assign head     = mem[rd_ptr];
  assign do_enq   = enq && ready;
  assign do_deq   = deq && head_vld;

  // Next-state: kill matching entries, enqueue (also subject to kill), advance pointers.
  always_comb begin
    ofs = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      mem_n[i] = mem[i];
      if (kill_en && (mem[i].rd == kill_rd)) mem_n[i].rd = '0;
    end
    if (do_enq) begin
      mem_n[wr_ptr] = enq_entry;
      if (kill_en && (enq_entry.rd == kill_rd)) mem_n[wr_ptr].rd = '0;
    end
    wr_ptr_n = wr_ptr + PW'(do_enq);
    rd_ptr_n = rd_ptr + PW'(do_deq);
    count_n  = count + CW'(do_enq) - CW'(do_deq);
    // Slot i is occupied when its distance from the read pointer is below count.
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      ofs        = PW'(i) - rd_ptr_n;
      nxt_vld[i] = (CW'(ofs) < count_n);
      nxt_rd[i]  = mem_n[i].rd;
    end
  end

  // State registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rst_q  <= 1'b1;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      count  <= count_n;
      rst_q  <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= mem_n[i];
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results take priority, buffered load
// results drain when the ALU is idle. Optional feature macro WB_STATS_EN adds
// a saturating Stall_Count output.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Alu_Valid,
  input  logic [REG_ADDR_W-1:0] Alu_Rd,
  input  logic [XLEN-1:0]       Alu_Data,
  input  logic                  Ld_Valid,
  output logic                  Ld_Ready,
  input  logic [REG_ADDR_W-1:0] Ld_Rd,
  input  logic [XLEN-1:0]       Ld_Data,
  output logic [REG_ADDR_W-1:0] Rd_Addr,
  output logic [XLEN-1:0]       Rd_Data,
  output logic [31:0]           Busy_Mask
`ifdef WB_STATS_EN
  ,
  output logic [15:0]           Stall_Count
`endif
);

  wb_entry_t                             ld_entry;
  wb_entry_t                             head;
  logic                                  head_vld;
  logic                                  kill_en;
  logic                                  ld_enq;
  logic [FIFO_DEPTH-1:0]                 nxt_vld;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] nxt_rd;
  logic [REG_ADDR_W-1:0]                 sel_addr;
  logic [XLEN-1:0]                       sel_data;
  logic [31:0]                           busy_n;

  assign ld_entry = '{rd: Ld_Rd, data: Ld_Data};
  // Loads to x0 are handshaken but never stored.
  assign ld_enq   = Ld_Valid && (Ld_Rd != '0);
  assign kill_en  = Alu_Valid && (Alu_Rd != '0);

  wb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .enq       (ld_enq),
    .enq_entry (ld_entry),
    .deq       (!Alu_Valid),
    .kill_en   (kill_en),
    .kill_rd   (Alu_Rd),
    .ready     (Ld_Ready),
    .head_vld  (head_vld),
    .head      (head),
    .nxt_vld   (nxt_vld),
    .nxt_rd    (nxt_rd)
  );

  // Priority select: ALU, else FIFO head; killed entries and x0 become idle writes.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    if (Alu_Valid) begin
      if (Alu_Rd != '0) begin
        sel_addr = Alu_Rd;
        sel_data = Alu_Data;
      end
    end else if (head_vld && (head.rd != '0)) begin
      sel_addr = head.rd;
      sel_data = head.data;
    end
  end

  // Busy mask from next-state buffer contents so it tracks the buffer exactly.
  always_comb begin
    busy_n = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (nxt_vld[i]) busy_n[nxt_rd[i]] = 1'b1;
    end
    busy_n[0] = 1'b0;
  end

  // Output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Rd_Addr   <= '0;
      Rd_Data   <= '0;
      Busy_Mask <= '0;
    end else begin
      Rd_Addr   <= sel_addr;
      Rd_Data   <= sel_data;
      Busy_Mask <= busy_n;
    end
  end

`ifdef WB_STATS_EN
  logic [15:0] stall_cnt;

  // Saturating count of offered-but-refused load cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt <= '0;
    end else if (Ld_Valid && !Ld_Ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign Stall_Count = stall_cnt;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a write scoreboard checked on every negedge.
module tb_wb_arbiter;

  logic        Clk;
  logic        Reset;
  logic        Alu_Valid;
  logic [4:0]  Alu_Rd;
  logic [31:0] Alu_Data;
  logic        Ld_Valid;
  logic        Ld_Ready;
  logic [4:0]  Ld_Rd;
  logic [31:0] Ld_Data;
  logic [4:0]  Rd_Addr;
  logic [31:0] Rd_Data;
  logic [31:0] Busy_Mask;
`ifdef WB_STATS_EN
  logic [15:0] Stall_Count;
`endif

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Alu_Valid (Alu_Valid),
    .Alu_Rd    (Alu_Rd),
    .Alu_Data  (Alu_Data),
    .Ld_Valid  (Ld_Valid),
    .Ld_Ready  (Ld_Ready),
    .Ld_Rd     (Ld_Rd),
    .Ld_Data   (Ld_Data),
    .Rd_Addr   (Rd_Addr),
    .Rd_Data   (Rd_Data),
    .Busy_Mask (Busy_Mask)
`ifdef WB_STATS_EN
    ,
    .Stall_Count (Stall_Count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    Alu_Valid = av; Alu_Rd = ard; Alu_Data = ad;
    Ld_Valid  = lv; Ld_Rd  = lrd; Ld_Data  = ld;
  endtask

  function automatic wr_t mk(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  // Every register-file write must be the next expected one; idle cycles carry zero data.
  always @(negedge Clk) begin
    if (mon_en) begin
      if (Rd_Addr !== 5'd0) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write: observed rd=%0d data=%h expected no write", Rd_Addr, Rd_Data);
        end
        if (sb.size() != 0) begin
          wr_t e;
          e = sb.pop_front();
          chk("wb_write", {27'd0, Rd_Addr, Rd_Data}, {27'd0, e.a, e.d});
        end
      end else begin
        chk("idle_data", {32'd0, Rd_Data}, 64'd0);
      end
    end
  end

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_addr",  {59'd0, Rd_Addr}, 64'd0);
    chk("rst_data",  {32'd0, Rd_Data}, 64'd0);
    chk("rst_busy",  {32'd0, Busy_Mask}, 64'd0);
    chk("rst_ready", {63'd0, Ld_Ready}, 64'd0);
    Reset = 1'b0;
    step();
    chk("ready_after_rst", {63'd0, Ld_Ready}, 64'd1);
    mon_en = 1'b1;

    // ALU only
    sb.push_back(mk(5, 32'h1234));
    drive(1, 5, 32'h1234, 0, 0, 0);
    step();
    chk("alu_addr", {59'd0, Rd_Addr}, 64'd5);
    chk("alu_data", {32'd0, Rd_Data}, 64'h1234);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("alu_idle", {59'd0, Rd_Addr}, 64'd0);

    // Single load drain
    sb.push_back(mk(7, 32'hAA));
    drive(0, 0, 0, 1, 7, 32'hAA);
    chk("ld_ready", {63'd0, Ld_Ready}, 64'd1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("ld_busy", {32'd0, Busy_Mask}, 64'h80);
    chk("ld_not_yet", {59'd0, Rd_Addr}, 64'd0);
    step();
    chk("ld_addr", {59'd0, Rd_Addr}, 64'd7);
    chk("ld_data", {32'd0, Rd_Data}, 64'hAA);
    chk("ld_busy_clr", {32'd0, Busy_Mask}, 64'd0);
    step();

    // Backpressure: ALU every cycle, three loads offered
    sb.push_back(mk(1, 32'hA0)); sb.push_back(mk(2, 32'hA1));
    sb.push_back(mk(3, 32'hA2)); sb.push_back(mk(4, 32'hA3));
    sb.push_back(mk(10, 32'h100)); sb.push_back(mk(11, 32'h101));
    sb.push_back(mk(12, 32'h102));
    drive(1, 1, 32'hA0, 1, 10, 32'h100);
    chk("bp_ready0", {63'd0, Ld_Ready}, 64'd1);
    step();
    drive(1, 2, 32'hA1, 1, 11, 32'h101);
    chk("bp_ready1", {63'd0, Ld_Ready}, 64'd1);
    step();
    chk("bp_busy_full", {32'd0, Busy_Mask}, 64'hC00);
    drive(1, 3, 32'hA2, 1, 12, 32'h102);
    chk("bp_ready2", {63'd0, Ld_Ready}, 64'd0);
    step();
    drive(1, 4, 32'hA3, 1, 12, 32'h102);
    chk("bp_ready3", {63'd0, Ld_Ready}, 64'd0);
    step();
    drive(0, 0, 0, 1, 12, 32'h102);
    chk("bp_ready_deq", {63'd0, Ld_Ready}, 64'd0);
    step();
    chk("bp_drain0", {59'd0, Rd_Addr}, 64'd10);
    chk("bp_busy1", {32'd0, Busy_Mask}, 64'h800);
    chk("bp_ready4", {63'd0, Ld_Ready}, 64'd1);
    step();
    chk("bp_drain1", {59'd0, Rd_Addr}, 64'd11);
    chk("bp_busy2", {32'd0, Busy_Mask}, 64'h1000);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("bp_drain2", {59'd0, Rd_Addr}, 64'd12);
    chk("bp_busy3", {32'd0, Busy_Mask}, 64'd0);

    // WAW kill of a buffered load
    drive(0, 0, 0, 1, 9, 32'h99);
    step();
    chk("waw_busy", {32'd0, Busy_Mask}, 64'h200);
    sb.push_back(mk(9, 32'h55));
    drive(1, 9, 32'h55, 0, 0, 0);
    step();
    chk("waw_busy_clr", {32'd0, Busy_Mask}, 64'd0);
    chk("waw_alu", {59'd0, Rd_Addr}, 64'd9);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("waw_noop", {59'd0, Rd_Addr}, 64'd0);

    // WAW kill of a load enqueued in the same cycle
    sb.push_back(mk(8, 32'h66));
    drive(1, 8, 32'h66, 1, 8, 32'h77);
    step();
    chk("waw_same_addr", {59'd0, Rd_Addr}, 64'd8);
    chk("waw_same_busy", {32'd0, Busy_Mask}, 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("waw_same_noop", {59'd0, Rd_Addr}, 64'd0);
    step();

    // ALU to x0 neither writes nor kills; load to x0 is consumed, not stored
    drive(1, 0, 32'hDEAD, 1, 4, 32'h44);
    step();
    chk("x0_alu_addr", {59'd0, Rd_Addr}, 64'd0);
    chk("x0_busy", {32'd0, Busy_Mask}, 64'h10);
    drive(1, 0, 32'hDEAD, 1, 0, 32'hBAD);
    chk("x0_ready_a", {63'd0, Ld_Ready}, 64'd1);
    step();
    chk("x0_nokill", {32'd0, Busy_Mask}, 64'h10);
    drive(1, 0, 32'hDEAD, 1, 0, 32'hBAD);
    chk("x0_ld_not_stored", {63'd0, Ld_Ready}, 64'd1);
    step();
    sb.push_back(mk(4, 32'h44));
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("x0_drain", {59'd0, Rd_Addr}, 64'd4);
    step();

    // Reset with two buffered loads
    drive(1, 0, 0, 1, 20, 32'h200);
    step();
    sb.push_back(mk(30, 32'h300));
    drive(1, 30, 32'h300, 1, 21, 32'h201);
    step();
    chk("rb_busy", {32'd0, Busy_Mask}, 64'h0030_0000);
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("rb_addr", {59'd0, Rd_Addr}, 64'd0);
    chk("rb_busy_clr", {32'd0, Busy_Mask}, 64'd0);
    chk("rb_ready", {63'd0, Ld_Ready}, 64'd0);
    step();
    Reset = 1'b0;
    step();
    chk("rb_ready_rel", {63'd0, Ld_Ready}, 64'd1);
    repeat (4) step();
    chk("rb_busy_rel", {32'd0, Busy_Mask}, 64'd0);

`ifdef WB_STATS_EN
    // Stall counter: fill, then five refused offers, then saturation
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
    drive(1, 0, 0, 1, 22, 32'h220);
    step();
    drive(1, 0, 0, 1, 23, 32'h230);
    step();
    drive(1, 0, 0, 1, 24, 32'h240);
    repeat (5) step();
    chk("stall_5", {48'd0, Stall_Count}, 64'd5);
    force dut.stall_cnt = 16'hFFFD;
    #1;
    release dut.stall_cnt;
    repeat (3) step();
    chk("stall_sat", {48'd0, Stall_Count}, 64'hFFFF);
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    Reset = 1'b0;
    repeat (3) step();
`endif

    drive(0, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2; load-result buffer depth, power of two, at least 2.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Alu_Valid  input  1  ALU result present this cycle; no backpressure.
REQ-005 Alu_Rd  input  5  ALU destination register.
REQ-006 Alu_Data  input  32  ALU result.
REQ-007 Ld_Valid  input  1  load result offered.
REQ-008 Ld_Ready  output  1  buffer can accept a load result.
REQ-009 Ld_Rd  input  5  load destination register.
REQ-010 Ld_Data  input  32  load result.
REQ-011 Rd_Addr  output  5  register-file write address; 0 means no write.
REQ-012 Rd_Data  output  32  register-file write data.
REQ-013 Busy_Mask  output  32  bit i set while a buffered load targets register i.

Function
REQ-014 Block SHALL be the single writer of the register-file write port; idle cycles SHALL drive Rd_Addr=0 and Rd_Data=0.
- Reason: the register file writes every cycle unless the address is 0.
REQ-015 Rd_Addr/Rd_Data SHALL be registered; a source selected in cycle N appears on the outputs after edge N.
REQ-016 Priority SHALL be ALU first, then the FIFO head.
- The FIFO head is dequeued only in a cycle with Alu_Valid=0.
REQ-017 A load SHALL be accepted when Ld_Valid && Ld_Ready.
- Ld_Ready SHALL be (count < FIFO_DEPTH), derived from registered state only.
- A dequeue in the same cycle SHALL NOT raise Ld_Ready.
REQ-018 An accepted load with Ld_Rd=0 SHALL be consumed but not stored.
REQ-019 Simultaneous ALU write and load accept SHALL both complete in the same cycle: ALU written, load enqueued.
REQ-020 Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve order.
REQ-021 WAW kill: when Alu_Valid with Alu_Rd != 0 matches the rd of any buffered entry, those entries SHALL have rd cleared to 0 at the same edge.
- A killed entry drains as a no-op cycle (Rd_Addr=0).
REQ-022 WAW kill SHALL also apply to a load being enqueued in the same cycle with Ld_Rd == Alu_Rd; that load is stored with rd=0.
REQ-023 Busy_Mask SHALL be the OR of one-hot rd over valid entries, registered; bit 0 SHALL always read 0.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-025 Alu_Valid with Alu_Rd=0 SHALL produce Rd_Addr=0 and SHALL NOT kill entries.

Reset
REQ-026 While Reset=1, at the next edge:
- Rd_Addr=0, Rd_Data=0, Busy_Mask=0.
- FIFO pointers and count = 0.
- Ld_Ready SHALL be forced to 0.
REQ-027 Reset mid-operation SHALL discard all buffered loads; no write SHALL be issued for them after reset.

Configuration
REQ-028 Macro WB_STATS_EN SHALL add output Stall_Count (16 bits).
- Increments each cycle Ld_Valid && !Ld_Ready.
- Saturates at 16'hFFFF.
- Reset value 0.
REQ-029 Without WB_STATS_EN, the Stall_Count port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Shared package wb_pkg SHALL hold:
- XLEN=32 and REG_ADDR_W=5.
- The entry typedef {rd, data}.
REQ-031 Buffer SHALL be a sub-module wb_fifo with enqueue, dequeue, kill-match, and per-entry rd outputs.
REQ-032 wb_arbiter SHALL hold the output registers, priority select, and Busy_Mask.

Verification
REQ-033 ALU only: Alu_Valid=1, Alu_Rd=5, Alu_Data=0x1234 for one cycle -> next cycle Rd_Addr=5, Rd_Data=0x1234; following cycle Rd_Addr=0.
REQ-034 Load drain: load rd=7 data=0xAA, ALU idle -> Busy_Mask=0x80 for one cycle; Rd_Addr=7, Rd_Data=0xAA two edges after accept; then Busy_Mask=0.
REQ-035 Backpressure: ALU valid every cycle, 3 loads offered -> Ld_Ready=0 after 2 accepts; no load write until ALU idles; loads then drain in order.
REQ-036 WAW kill: load rd=9 buffered, then ALU rd=9 data=0x55 -> Busy_Mask bit 9 clears; register 9 is written only with 0x55; a no-op drain cycle follows.
REQ-037 Reset with 2 buffered loads -> Rd_Addr=0, Busy_Mask=0, Ld_Ready=0 during reset; no load writes after release.
REQ-038 With WB_STATS_EN defined: 5 stalled cycles -> Stall_Count=5; a forced near-saturation case holds at 0xFFFF.
